mc_controller: RTL and testbench
================================

Name: mc_controller

Overview:
- Main control unit of the multicycle 32-bit MIPS-subset processor; sits directly upstream of the ALU.
- Moore FSM sequences fetch/decode/execute/memory/writeback over several cycles. Decodes opcode and funct into the ALU function select F[2:0] and all datapath enables and mux selects.
- Consumes the ALU zero_flag to resolve beq and drive the PC enable.

Parameters:
- FUNCT_MUL, 6'b011000: R-type funct decoded as multiply (ALU F=3'b011).

Ports:
- clk  input  1  system clock; all state changes on rising edge.
- reset  input  1  asynchronous, active-high reset.
- op  input  6  instruction opcode, instr[31:26], valid from DECODE onward.
- funct  input  6  instruction funct, instr[5:0].
- zero_flag  input  1  ALU zero result, combinational from ALU.
- alucontrol  output  3  ALU F select.
- alusrca  output  1  0=PC, 1=register A.
- alusrcb  output  2  00=B, 01=const 4, 10=sign-ext imm, 11=sign-ext imm<<2.
- pcsrc  output  2  00=ALU result, 01=ALUOut, 10=jump target.
- iord  output  1  memory address select: 0=PC, 1=ALUOut.
- irwrite  output  1  instruction register load.
- memwrite  output  1  data memory write strobe.
- regdst  output  1  0=rt, 1=rd.
- memtoreg  output  1  0=ALUOut, 1=memory data.
- regwrite  output  1  register file write enable.
- pcen  output  1  PC load enable.
- state  output  4  current FSM state, for debug.

Behaviour:
- Single clock. reset asserts asynchronously; while high, state=FETCH and all of irwrite, memwrite, regwrite, pcen are forced 0. Other outputs take their FETCH values: alusrca=0, alusrcb=01, alucontrol=010, pcsrc=00, iord=0, regdst=0, memtoreg=0.
- After reset deasserts, the first rising edge executes FETCH normally. Reset mid-instruction aborts it with no further writes.
- Outputs are a combinational Moore decode of state, except alucontrol in EXECUTE (also uses funct) and pcen.
- Opcodes: 000000 R-type, 100011 lw, 101011 sw, 000100 beq, 001000 addi, 000010 j.
- State encoding and outputs not listed are 0/don't-write:
  - FETCH(0): iord=0, alusrca=0, alusrcb=01, alucontrol=010, pcsrc=00, irwrite=1, pcwrite=1. Next DECODE.
  - DECODE(1): alusrca=0, alusrcb=11, alucontrol=010 (branch target into ALUOut). Next by op: lw/sw->MEMADR, R-type->EXECUTE, beq->BRANCH, addi->ADDIEX, j->JUMP. Unknown op->FETCH with no writes. R-type with unsupported funct->FETCH.
  - MEMADR(2): alusrca=1, alusrcb=10, alucontrol=010. Next lw->MEMRD, sw->MEMWR.
  - MEMRD(3): iord=1. Next MEMWB.
  - MEMWB(4): regdst=0, memtoreg=1, regwrite=1. Next FETCH.
  - MEMWR(5): iord=1, memwrite=1. Next FETCH.
  - EXECUTE(6): alusrca=1, alusrcb=00, alucontrol from funct: 100000->010, 100010->110, 100100->000, 100101->001, 101010->111, FUNCT_MUL->011. Next ALUWB.
  - ALUWB(7): regdst=1, memtoreg=0, regwrite=1. Next FETCH.
  - BRANCH(8): alusrca=1, alusrcb=00, alucontrol=110, pcsrc=01, branch=1. Next FETCH.
  - ADDIEX(9): alusrca=1, alusrcb=10, alucontrol=010. Next ADDIWB.
  - ADDIWB(10): regdst=0, memtoreg=0, regwrite=1. Next FETCH.
  - JUMP(11): pcsrc=10, pcwrite=1. Next FETCH.
- Encodings 12-15 are illegal; the FSM goes to FETCH on the next edge with no writes.
- pcen = pcwrite | (branch & zero_flag). zero_flag is sampled in the same cycle as BRANCH, with no pipeline.
- Cycle counts: lw 5, sw 4, R-type 4, addi 4, beq 3, j 3. Unsupported op/funct 2.

Optional Feature:
- ALU_MUL_EN defined: FUNCT_MUL decodes as supported (EXECUTE emits 011).
- Undefined: FUNCT_MUL is an unsupported funct, so DECODE->FETCH with no regwrite. alucontrol never equals 011.

Test Plan:
- Reset pulsed mid-MEMRD (state=3) -> state=0 immediately (asynchronous); irwrite/pcen/regwrite/memwrite=0 while reset high. First post-reset edge has irwrite=1, pcen=1.
- lw (op=100011) -> states 0,1,2,3,4,0. MEMADR alucontrol=010, alusrcb=10. MEMWB regwrite=1, memtoreg=1, regdst=0.
- R-type funct=100010 -> EXECUTE alucontrol=110, alusrca=1, alusrcb=00. ALUWB regwrite=1, regdst=1. 4 cycles total.
- beq with zero_flag=1 -> BRANCH pcen=1, pcsrc=01. Repeat with zero_flag=0 -> pcen=0. Returns to FETCH either case.
- op=111111 -> 0,1,0, no regwrite/memwrite asserted. R-type funct=011000 -> with ALU_MUL_EN: EXECUTE alucontrol=011 then ALUWB. Without: DECODE->FETCH, regwrite never 1.
- j (op=000010) -> JUMP pcsrc=10, pcen=1. sw -> MEMWR memwrite=1, iord=1 for exactly one cycle.

Source files
------------

// File: rtl/mc_controller.sv
// ============================================================================
// mc_controller
// ----------------------------------------------------------------------------
// Main control unit for a multicycle 32-bit MIPS-subset processor. A Moore FSM
// walks each instruction through fetch / decode / execute / memory / writeback
// and decodes opcode + funct into the ALU function select and every datapath
// enable and mux select.
//
// Optional feature macro: ALU_MUL_EN
//   defined   : R-type funct FUNCT_MUL is supported, EXECUTE drives F=3'b011.
//   undefined : FUNCT_MUL is treated as an unsupported funct (DECODE->FETCH),
//               so alucontrol can never be 3'b011.
//
// Ports:
//   clk         in   1  system clock, rising edge
//   reset       in   1  asynchronous active-high reset
//   op          in   6  instr[31:26], valid from DECODE onward
//   funct       in   6  instr[5:0]
//   zero_flag   in   1  ALU zero result (combinational from the ALU)
//   alucontrol  out  3  ALU F select
//   alusrca     out  1  0=PC, 1=register A
//   alusrcb     out  2  00=B, 01=4, 10=sext imm, 11=sext imm<<2
//   pcsrc       out  2  00=ALU result, 01=ALUOut, 10=jump target
//   iord        out  1  memory address: 0=PC, 1=ALUOut
//   irwrite     out  1  instruction register load
//   memwrite    out  1  data memory write strobe
//   regdst      out  1  0=rt, 1=rd
//   memtoreg    out  1  0=ALUOut, 1=memory data
//   regwrite    out  1  register file write enable
//   pcen        out  1  PC load enable
//   state       out  4  current FSM state (debug)
// ============================================================================
module mc_controller #(
    parameter logic [5:0] FUNCT_MUL = 6'b011000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] op,
    input  logic [5:0] funct,
    input  logic       zero_flag,
    output logic [2:0] alucontrol,
    output logic       alusrca,
    output logic [1:0] alusrcb,
    output logic [1:0] pcsrc,
    output logic       iord,
    output logic       irwrite,
    output logic       memwrite,
    output logic       regdst,
    output logic       memtoreg,
    output logic       regwrite,
    output logic       pcen,
    output logic [3:0] state
);

    // ------------------------------------------------------------------------
    // Encodings
    // ------------------------------------------------------------------------
    typedef enum logic [3:0] {
        S_FETCH   = 4'd0,
        S_DECODE  = 4'd1,
        S_MEMADR  = 4'd2,
        S_MEMRD   = 4'd3,
        S_MEMWB   = 4'd4,
        S_MEMWR   = 4'd5,
        S_EXECUTE = 4'd6,
        S_ALUWB   = 4'd7,
        S_BRANCH  = 4'd8,
        S_ADDIEX  = 4'd9,
        S_ADDIWB  = 4'd10,
        S_JUMP    = 4'd11
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_SLT = 6'b101010;

    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_MUL = 3'b011;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_SLT = 3'b111;

    // ------------------------------------------------------------------------
    // Signals
    // ------------------------------------------------------------------------
    state_t     r_state;
    state_t     w_next_state;

    logic       w_funct_ok;     // funct names an operation this build supports
    logic [2:0] w_funct_alu;    // ALU select for that funct

    logic       w_pcwrite;
    logic       w_branch;
    logic       w_irwrite;
    logic       w_memwrite;
    logic       w_regwrite;

    // ------------------------------------------------------------------------
    // R-type funct decode. Shared by DECODE (to reject unsupported functs
    // early) and EXECUTE (to pick the ALU operation).
    // ------------------------------------------------------------------------
    always_comb begin
        w_funct_ok  = 1'b1;
        w_funct_alu = ALU_ADD;
        case (funct)
            FN_ADD:    w_funct_alu = ALU_ADD;
            FN_SUB:    w_funct_alu = ALU_SUB;
            FN_AND:    w_funct_alu = ALU_AND;
            FN_OR:     w_funct_alu = ALU_OR;
            FN_SLT:    w_funct_alu = ALU_SLT;
`ifdef ALU_MUL_EN
            FUNCT_MUL: w_funct_alu = ALU_MUL;
`endif
            default: begin
                // Never reaches EXECUTE; ADD keeps 3'b011 unreachable here.
                w_funct_ok  = 1'b0;
                w_funct_alu = ALU_ADD;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_FETCH;
        end else begin
            r_state <= w_next_state;
        end
    end

    // ------------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------------
    always_comb begin
        w_next_state = S_FETCH;
        case (r_state)
            S_FETCH:   w_next_state = S_DECODE;
            S_DECODE: begin
                case (op)
                    OP_LW, OP_SW: w_next_state = S_MEMADR;
                    OP_RTYPE:     w_next_state = w_funct_ok ? S_EXECUTE : S_FETCH;
                    OP_BEQ:       w_next_state = S_BRANCH;
                    OP_ADDI:      w_next_state = S_ADDIEX;
                    OP_J:         w_next_state = S_JUMP;
                    default:      w_next_state = S_FETCH;
                endcase
            end
            // op is held stable through the instruction, so it still
            // distinguishes lw from sw here.
            S_MEMADR:  w_next_state = (op == OP_SW) ? S_MEMWR : S_MEMRD;
            S_MEMRD:   w_next_state = S_MEMWB;
            S_MEMWB:   w_next_state = S_FETCH;
            S_MEMWR:   w_next_state = S_FETCH;
            S_EXECUTE: w_next_state = S_ALUWB;
            S_ALUWB:   w_next_state = S_FETCH;
            S_BRANCH:  w_next_state = S_FETCH;
            S_ADDIEX:  w_next_state = S_ADDIWB;
            S_ADDIWB:  w_next_state = S_FETCH;
            S_JUMP:    w_next_state = S_FETCH;
            default:   w_next_state = S_FETCH;   // 12-15: recover, no writes
        endcase
    end

    // ------------------------------------------------------------------------
    // Output decode (Moore, except EXECUTE's alucontrol and pcen)
    // ------------------------------------------------------------------------
    always_comb begin
        alucontrol = 3'b000;
        alusrca    = 1'b0;
        alusrcb    = 2'b00;
        pcsrc      = 2'b00;
        iord       = 1'b0;
        regdst     = 1'b0;
        memtoreg   = 1'b0;
        w_irwrite  = 1'b0;
        w_memwrite = 1'b0;
        w_regwrite = 1'b0;
        w_pcwrite  = 1'b0;
        w_branch   = 1'b0;
        case (r_state)
            S_FETCH: begin
                alusrcb    = 2'b01;
                alucontrol = ALU_ADD;
                w_irwrite  = 1'b1;
                w_pcwrite  = 1'b1;
            end
            S_DECODE: begin
                // Precompute the branch target into ALUOut.
                alusrcb    = 2'b11;
                alucontrol = ALU_ADD;
            end
            S_MEMADR: begin
                alusrca    = 1'b1;
                alusrcb    = 2'b10;
                alucontrol = ALU_ADD;
            end
            S_MEMRD: begin
                iord = 1'b1;
            end
            S_MEMWB: begin
                memtoreg   = 1'b1;
                w_regwrite = 1'b1;
            end
            S_MEMWR: begin
                iord       = 1'b1;
                w_memwrite = 1'b1;
            end
            S_EXECUTE: begin
                alusrca    = 1'b1;
                alucontrol = w_funct_alu;
            end
            S_ALUWB: begin
                regdst     = 1'b1;
                w_regwrite = 1'b1;
            end
            S_BRANCH: begin
                alusrca    = 1'b1;
                alucontrol = ALU_SUB;
                pcsrc      = 2'b01;
                w_branch   = 1'b1;
            end
            S_ADDIEX: begin
                alusrca    = 1'b1;
                alusrcb    = 2'b10;
                alucontrol = ALU_ADD;
            end
            S_ADDIWB: begin
                w_regwrite = 1'b1;
            end
            S_JUMP: begin
                pcsrc     = 2'b10;
                w_pcwrite = 1'b1;
            end
            default: begin
                // Illegal encodings: everything stays at its idle value.
            end
        endcase
    end

    // While reset is high the state already reads FETCH, so the mux selects
    // show FETCH values; only the write strobes need explicit suppression.
    assign irwrite  = w_irwrite  & ~reset;
    assign memwrite = w_memwrite & ~reset;
    assign regwrite = w_regwrite & ~reset;
    // zero_flag is used in the same cycle as BRANCH; no pipelining.
    assign pcen     = (w_pcwrite | (w_branch & zero_flag)) & ~reset;
    assign state    = r_state;

endmodule

// File: tb/tb_mc_controller.sv
// ============================================================================
// tb_mc_controller
// ----------------------------------------------------------------------------
// Directed self-checking bench for mc_controller. Each instruction is stepped
// one clock at a time; every step compares the state and a packed word of all
// control outputs against hand-computed values.
// ctl = {alucontrol, alusrca, alusrcb, pcsrc, iord, irwrite, memwrite,
//        regdst, memtoreg, regwrite, pcen}
// ============================================================================
module tb_mc_controller;

    logic       clk = 1'b0;
    logic       reset;
    logic [5:0] op;
    logic [5:0] funct;
    logic       zero_flag;

    logic [2:0] alucontrol;
    logic       alusrca;
    logic [1:0] alusrcb;
    logic [1:0] pcsrc;
    logic       iord;
    logic       irwrite;
    logic       memwrite;
    logic       regdst;
    logic       memtoreg;
    logic       regwrite;
    logic       pcen;
    logic [3:0] state;

    int vectors     = 0;
    int miscompares = 0;

    mc_controller dut (
        .clk        (clk),
        .reset      (reset),
        .op         (op),
        .funct      (funct),
        .zero_flag  (zero_flag),
        .alucontrol (alucontrol),
        .alusrca    (alusrca),
        .alusrcb    (alusrcb),
        .pcsrc      (pcsrc),
        .iord       (iord),
        .irwrite    (irwrite),
        .memwrite   (memwrite),
        .regdst     (regdst),
        .memtoreg   (memtoreg),
        .regwrite   (regwrite),
        .pcen       (pcen),
        .state      (state)
    );

    always #5 clk = ~clk;

    wire [14:0] ctl = {alucontrol, alusrca, alusrcb, pcsrc, iord, irwrite,
                       memwrite, regdst, memtoreg, regwrite, pcen};

    //                          alu  a  b  pcs io ir mw rd mr rw pe
    localparam logic [14:0] C_RST    = 15'b010_0_01_00_0_0_0_0_0_0_0;
    localparam logic [14:0] C_FETCH  = 15'b010_0_01_00_0_1_0_0_0_0_1;
    localparam logic [14:0] C_DECODE = 15'b010_0_11_00_0_0_0_0_0_0_0;
    localparam logic [14:0] C_MEMADR = 15'b010_1_10_00_0_0_0_0_0_0_0;
    localparam logic [14:0] C_MEMRD  = 15'b000_0_00_00_1_0_0_0_0_0_0;
    localparam logic [14:0] C_MEMWB  = 15'b000_0_00_00_0_0_0_0_1_1_0;
    localparam logic [14:0] C_MEMWR  = 15'b000_0_00_00_1_0_1_0_0_0_0;
    localparam logic [14:0] C_ALUWB  = 15'b000_0_00_00_0_0_0_1_0_1_0;
    localparam logic [14:0] C_BR_T   = 15'b110_1_00_01_0_0_0_0_0_0_1;
    localparam logic [14:0] C_BR_NT  = 15'b110_1_00_01_0_0_0_0_0_0_0;
    localparam logic [14:0] C_ADDIEX = 15'b010_1_10_00_0_0_0_0_0_0_0;
    localparam logic [14:0] C_ADDIWB = 15'b000_0_00_00_0_0_0_0_0_1_0;
    localparam logic [14:0] C_JUMP   = 15'b000_0_00_10_0_0_0_0_0_0_1;
    localparam logic [14:0] C_EX_ADD = 15'b010_1_00_00_0_0_0_0_0_0_0;
    localparam logic [14:0] C_EX_SUB = 15'b110_1_00_00_0_0_0_0_0_0_0;
    localparam logic [14:0] C_EX_AND = 15'b000_1_00_00_0_0_0_0_0_0_0;
    localparam logic [14:0] C_EX_OR  = 15'b001_1_00_00_0_0_0_0_0_0_0;
    localparam logic [14:0] C_EX_SLT = 15'b111_1_00_00_0_0_0_0_0_0_0;
    localparam logic [14:0] C_EX_MUL = 15'b011_1_00_00_0_0_0_0_0_0_0;

    // Advance one clock; outputs are looked at 2 time units after the edge.
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic test_reset();
        reset = 1'b1; op = 6'b111111; funct = 6'b0; zero_flag = 1'b0;
        tick();
        vectors++;
        if (state !== 4'd0 || ctl !== C_RST) begin
            $display("FAIL reset_hold: state=%0d ctl=%b required state=0 ctl=%b", state, ctl, C_RST);
            miscompares++;
        end
        reset = 1'b0;
        #1;
        vectors++;
        if (state !== 4'd0 || ctl !== C_FETCH) begin
            $display("FAIL reset_release: state=%0d ctl=%b required state=0 ctl=%b", state, ctl, C_FETCH);
            miscompares++;
        end
        $display("reset: released, FETCH outputs live");
        // Finish with unknown op: FETCH -> DECODE -> FETCH.
        tick();
        tick();
    endtask

    task automatic test_reset_mid_memrd();
        op = 6'b100011;
        tick(); tick(); tick();
        vectors++;
        if (state !== 4'd3 || ctl !== C_MEMRD) begin
            $display("FAIL rst_mid_pre: state=%0d ctl=%b required state=3 ctl=%b", state, ctl, C_MEMRD);
            miscompares++;
        end
        #2;
        reset = 1'b1;
        #1;
        vectors++;
        if (state !== 4'd0 || ctl !== C_RST) begin
            $display("FAIL rst_mid_async: state=%0d ctl=%b required state=0 ctl=%b", state, ctl, C_RST);
            miscompares++;
        end
        tick();
        vectors++;
        if (state !== 4'd0 || ctl !== C_RST) begin
            $display("FAIL rst_mid_edge: state=%0d ctl=%b required state=0 ctl=%b", state, ctl, C_RST);
            miscompares++;
        end
        reset = 1'b0;
        op = 6'b111111;
        #1;
        vectors++;
        if (ctl !== C_FETCH) begin
            $display("FAIL rst_mid_release: ctl=%b required %b", ctl, C_FETCH);
            miscompares++;
        end
        tick();
        vectors++;
        if (state !== 4'd1 || ctl !== C_DECODE) begin
            $display("FAIL rst_mid_first_edge: state=%0d ctl=%b required state=1 ctl=%b", state, ctl, C_DECODE);
            miscompares++;
        end
        tick();
        $display("reset_mid_memrd: lw aborted in MEMRD");
    endtask

    task automatic test_lw();
        logic [3:0]  es [6] = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd0};
        logic [14:0] ec [6] = '{C_FETCH, C_DECODE, C_MEMADR, C_MEMRD, C_MEMWB, C_FETCH};
        op = 6'b100011;
        for (int i = 0; i < 6; i++) begin
            vectors++;
            if (state !== es[i] || ctl !== ec[i]) begin
                $display("FAIL lw step%0d: state=%0d ctl=%b required state=%0d ctl=%b", i, state, ctl, es[i], ec[i]);
                miscompares++;
            end
            if (i < 5) tick();
        end
        $display("lw: 5-cycle sequence stepped");
    endtask

    task automatic test_sw();
        logic [3:0]  es [5] = '{4'd0, 4'd1, 4'd2, 4'd5, 4'd0};
        logic [14:0] ec [5] = '{C_FETCH, C_DECODE, C_MEMADR, C_MEMWR, C_FETCH};
        op = 6'b101011;
        for (int i = 0; i < 5; i++) begin
            vectors++;
            if (state !== es[i] || ctl !== ec[i]) begin
                $display("FAIL sw step%0d: state=%0d ctl=%b required state=%0d ctl=%b", i, state, ctl, es[i], ec[i]);
                miscompares++;
            end
            if (i < 4) tick();
        end
        $display("sw: 4-cycle sequence stepped");
    endtask

    task automatic test_rtype();
        logic [5:0]  fn [5] = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010};
        logic [14:0] ex [5] = '{C_EX_ADD, C_EX_SUB, C_EX_AND, C_EX_OR, C_EX_SLT};
        logic [3:0]  es [5] = '{4'd0, 4'd1, 4'd6, 4'd7, 4'd0};
        logic [14:0] ec [5];
        op = 6'b000000;
        for (int k = 0; k < 5; k++) begin
            funct = fn[k];
            ec = '{C_FETCH, C_DECODE, ex[k], C_ALUWB, C_FETCH};
            for (int i = 0; i < 5; i++) begin
                vectors++;
                if (state !== es[i] || ctl !== ec[i]) begin
                    $display("FAIL rtype_%b step%0d: state=%0d ctl=%b required state=%0d ctl=%b", fn[k], i, state, ctl, es[i], ec[i]);
                    miscompares++;
                end
                if (i < 4) tick();
            end
            $display("rtype funct=%b: 4-cycle sequence stepped", fn[k]);
        end
    endtask

    task automatic test_addi();
        logic [3:0]  es [5] = '{4'd0, 4'd1, 4'd9, 4'd10, 4'd0};
        logic [14:0] ec [5] = '{C_FETCH, C_DECODE, C_ADDIEX, C_ADDIWB, C_FETCH};
        op = 6'b001000;
        for (int i = 0; i < 5; i++) begin
            vectors++;
            if (state !== es[i] || ctl !== ec[i]) begin
                $display("FAIL addi step%0d: state=%0d ctl=%b required state=%0d ctl=%b", i, state, ctl, es[i], ec[i]);
                miscompares++;
            end
            if (i < 4) tick();
        end
        $display("addi: 4-cycle sequence stepped");
    endtask

    task automatic test_branch();
        logic [3:0]  es [4] = '{4'd0, 4'd1, 4'd8, 4'd0};
        logic [14:0] ec [4];
        op = 6'b000100;
        for (int z = 1; z >= 0; z--) begin
            zero_flag = (z == 1);
            ec = '{C_FETCH, C_DECODE, (z == 1) ? C_BR_T : C_BR_NT, C_FETCH};
            for (int i = 0; i < 4; i++) begin
                vectors++;
                if (state !== es[i] || ctl !== ec[i]) begin
                    $display("FAIL beq_z%0d step%0d: state=%0d ctl=%b required state=%0d ctl=%b", z, i, state, ctl, es[i], ec[i]);
                    miscompares++;
                end
                if (i == 2) begin
                    // pcen must follow zero_flag combinationally inside BRANCH.
                    zero_flag = (z == 0);
                    #1;
                    vectors++;
                    if (pcen !== (z == 0)) begin
                        $display("FAIL beq_zero_follow_z%0d: pcen=%b required %b", z, pcen, (z == 0));
                        miscompares++;
                    end
                    zero_flag = (z == 1);
                end
                if (i < 3) tick();
            end
            $display("beq zero_flag=%0d: 3-cycle sequence stepped", z);
        end
        zero_flag = 1'b0;
    endtask

    task automatic test_jump();
        logic [3:0]  es [4] = '{4'd0, 4'd1, 4'd11, 4'd0};
        logic [14:0] ec [4] = '{C_FETCH, C_DECODE, C_JUMP, C_FETCH};
        op = 6'b000010;
        for (int i = 0; i < 4; i++) begin
            vectors++;
            if (state !== es[i] || ctl !== ec[i]) begin
                $display("FAIL j step%0d: state=%0d ctl=%b required state=%0d ctl=%b", i, state, ctl, es[i], ec[i]);
                miscompares++;
            end
            if (i < 3) tick();
        end
        $display("j: 3-cycle sequence stepped");
    endtask

    task automatic test_unsupported();
        logic [5:0] ops [2] = '{6'b111111, 6'b000000};
        logic [5:0] fns [2] = '{6'b100000, 6'b000000};
        for (int k = 0; k < 2; k++) begin
            op = ops[k]; funct = fns[k];
            vectors++;
            if (state !== 4'd0 || ctl !== C_FETCH) begin
                $display("FAIL unsup%0d fetch: state=%0d ctl=%b required state=0 ctl=%b", k, state, ctl, C_FETCH);
                miscompares++;
            end
            tick();
            vectors++;
            if (state !== 4'd1 || ctl !== C_DECODE) begin
                $display("FAIL unsup%0d decode: state=%0d ctl=%b required state=1 ctl=%b", k, state, ctl, C_DECODE);
                miscompares++;
            end
            tick();
            vectors++;
            if (state !== 4'd0 || ctl !== C_FETCH) begin
                $display("FAIL unsup%0d back: state=%0d ctl=%b required state=0 ctl=%b", k, state, ctl, C_FETCH);
                miscompares++;
            end
            $display("unsupported op=%b funct=%b: 2-cycle sequence stepped", ops[k], fns[k]);
        end
    endtask

    task automatic test_mul();
`ifdef ALU_MUL_EN
        logic [3:0]  es [5] = '{4'd0, 4'd1, 4'd6, 4'd7, 4'd0};
        logic [14:0] ec [5] = '{C_FETCH, C_DECODE, C_EX_MUL, C_ALUWB, C_FETCH};
        localparam int N = 5;
`else
        logic [3:0]  es [3] = '{4'd0, 4'd1, 4'd0};
        logic [14:0] ec [3] = '{C_FETCH, C_DECODE, C_FETCH};
        localparam int N = 3;
`endif
        op = 6'b000000; funct = 6'b011000;
        for (int i = 0; i < N; i++) begin
            vectors++;
            if (state !== es[i] || ctl !== ec[i]) begin
                $display("FAIL mul step%0d: state=%0d ctl=%b required state=%0d ctl=%b", i, state, ctl, es[i], ec[i]);
                miscompares++;
            end
            if (i < N - 1) tick();
        end
        $display("mul funct: %0d-cycle sequence stepped", N - 1);
    endtask

    initial begin
        test_reset();
        test_lw();
        test_sw();
        test_rtype();
        test_addi();
        test_branch();
        test_jump();
        test_unsupported();
        test_mul();
        test_reset_mid_memrd();
        // Back-to-back: lw immediately after the recovered reset.
        test_lw();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
